// File: rtl/bch_encoder.sv
// Systematic BCH(63,51) t=2 encoder: 51 message bits pass straight
// through, then 12 parity bits are shifted out of the divider register.
module bch_encoder #(
   parameter int          N        = 63,
   parameter int          K        = 51,
   parameter logic [12:0] GEN_POLY = 13'b1010100111001
) (
   input  logic clk,
   input  logic rst,
   input  logic in_valid,
   input  logic in_data,
   output logic in_ready,
   output logic out_valid,
   output logic out_data,
   input  logic out_ready
);

   localparam int PW = N - K;

   localparam logic [0:0] ST_MSG    = 1'b0;
   localparam logic [0:0] ST_PARITY = 1'b1;

   localparam logic [5:0] LAST_MSG = 6'(K - 1);
   localparam logic [5:0] LAST_BIT = 6'(N - 1);

   logic [0:0]    state_q,  state_d;
   logic [PW-1:0] parity_q, parity_d;
   logic [5:0]    cnt_q,    cnt_d;

   logic in_xfer;
   logic par_xfer;
   logic fb;
   logic in_msg;

   assign in_msg = (state_q == ST_MSG);

   // Handshake and data mux; everything is held off while in reset
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      out_data  = parity_q[PW-1];
      if (in_msg) begin
         out_data = in_data;
      end
      if (rst) begin
         if (in_msg) begin
            in_ready  = out_ready;
            out_valid = in_valid;
         end else begin
            out_valid = 1'b1;
         end
      end
   end

   assign in_xfer  = rst & in_msg & in_valid & out_ready;
   assign par_xfer = rst & ~in_msg & out_ready;
   assign fb       = in_data ^ parity_q[PW-1];

   // Divider update while message streams, plain shift while parity drains
   always_comb begin
      state_d  = state_q;
      parity_d = parity_q;
      cnt_d    = cnt_q;
      if (in_xfer) begin
         parity_d = {parity_q[PW-2:0], 1'b0}
                  ^ (fb ? GEN_POLY[PW-1:0] : '0);
         cnt_d    = cnt_q + 6'd1;
         if (cnt_q == LAST_MSG) begin
            state_d = ST_PARITY;
         end
      end else if (par_xfer) begin
         parity_d = {parity_q[PW-2:0], 1'b0};
         cnt_d    = cnt_q + 6'd1;
         if (cnt_q == LAST_BIT) begin
            cnt_d    = '0;
            parity_d = '0;
            state_d  = ST_MSG;
         end
      end
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= ST_MSG;
         parity_q <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         parity_q <= parity_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: tb/tb_bch_encoder.sv
// Scoreboard bench for bch_encoder: reference codewords come from
// polynomial long division of m(x)*x^12 by g(x).
module tb_bch_encoder;

   localparam logic [12:0] G = 13'b1010100111001;

   logic clk = 1'b0;
   logic rst;
   logic in_valid;
   logic in_data;
   logic in_ready;
   logic out_valid;
   logic out_data;
   logic out_ready;

   bch_encoder dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .out_valid(out_valid),
      .out_data (out_data),
      .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   bit in_q[$];
   bit exp_q[$];
   int n_cmp = 0;
   int n_err = 0;
   int in_duty = 100;
   int out_duty = 100;
   int n_in_xfer = 0;

   function automatic logic [11:0] ref_parity(input logic [50:0] m);
      logic [62:0] r;
      r = {m, 12'b0};
      for (int i = 62; i >= 12; i--) begin
         if (r[i]) r = r ^ (63'(G) << (i - 12));
      end
      return r[11:0];
   endfunction

   function automatic logic [50:0] rand_msg();
      logic [50:0] m;
      m = {$urandom(), $urandom()};
      return m;
   endfunction

   task automatic push_golden(input logic [50:0] m, input logic [11:0] p);
      for (int i = 50; i >= 0; i--) begin
         in_q.push_back(m[i]);
         exp_q.push_back(m[i]);
      end
      for (int i = 11; i >= 0; i--) exp_q.push_back(p[i]);
   endtask

   task automatic push_frame(input logic [50:0] m);
      push_golden(m, ref_parity(m));
   endtask

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, req);
      end
   endtask

   task automatic drain(input int budget);
      int c;
      c = 0;
      while ((exp_q.size() != 0 || in_q.size() != 0) && c < budget) begin
         @(posedge clk);
         c++;
      end
      check("drain_timeout", 32'(exp_q.size()), 32'd0);
      in_q.delete();
      exp_q.delete();
      #2;
   endtask

   // Driver: feeds queued message bits with a random valid/ready duty
   initial begin
      in_valid  = 1'b0;
      in_data   = 1'b0;
      out_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (in_q.size() > 0 && $urandom_range(99) < in_duty) begin
            in_valid = 1'b1;
            in_data  = in_q[0];
         end else begin
            in_valid = 1'b0;
         end
         out_ready = ($urandom_range(99) < out_duty);
         @(negedge clk);
         if (in_valid && in_ready) begin
            void'(in_q.pop_front());
            n_in_xfer++;
         end
      end
   end

   // Monitor: every output transfer is checked against the scoreboard
   initial begin
      int pos;
      int low;
      bit e;
      pos = 0;
      low = 0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            pos = 0;
            low = 0;
         end else if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_out", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               check("out_data", 32'(out_data), 32'(e));
            end
            if (!in_ready) low++;
            if (pos == 62) begin
               check("ready_low_per_frame", 32'(low), 32'd12);
               pos = 0;
               low = 0;
            end else begin
               pos++;
            end
         end
      end
   end

   initial begin
      int base;
      int c;
      rst = 1'b0;
      push_golden(51'd0, 12'h000);
      repeat (2) @(posedge clk);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("rst_out_valid", 32'(out_valid), 32'd0);
         check("rst_in_ready", 32'(in_ready), 32'd0);
      end
      @(posedge clk);
      #2;
      rst = 1'b1;
      drain(400);

      push_golden(51'd1, 12'h539);
      drain(400);

      for (int f = 0; f < 20; f++) push_frame(rand_msg());
      drain(4000);

      for (int f = 0; f < 30; f++) begin
         in_duty  = 30 + $urandom_range(60);
         out_duty = 30 + $urandom_range(60);
         push_frame(rand_msg());
         drain(1500);
      end
      in_duty  = 100;
      out_duty = 100;

      base = n_in_xfer;
      push_frame(rand_msg());
      c = 0;
      while (n_in_xfer < base + 20 && c < 200) begin
         @(negedge clk);
         c++;
      end
      check("abort_reach", 32'(n_in_xfer >= base + 20), 32'd1);
      @(posedge clk);
      #2;
      rst = 1'b0;
      in_q.delete();
      exp_q.delete();
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b1;
      push_golden(51'd1, 12'h539);
      drain(400);

      for (int f = 0; f < 5; f++) push_frame(rand_msg());
      c = 0;
      @(negedge clk);
      while (!out_valid && c < 20) begin
         @(negedge clk);
         c++;
      end
      for (int k = 0; k < 315; k++) begin
         check("b2b_out_valid", 32'(out_valid), 32'd1);
         check("b2b_in_ready", 32'(in_ready), 32'((k % 63) < 51));
         @(negedge clk);
      end
      drain(200);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule
